// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and lane encodings for the 4-lane TDM receive path
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } tdm_state_t;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    localparam lane_idx_t LANE_U = 2'd0;
    localparam lane_idx_t LANE_V = 2'd1;
    localparam lane_idx_t LANE_W = 2'd2;
    localparam lane_idx_t LANE_X = 2'd3;

endpackage

// File: rtl/tdm_demux_4.sv
// rtl/tdm_demux_4.sv - 4-lane TDM frame demultiplexer with atomic commit and readback
module tdm_demux_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] lane_u,
    output logic [WIDTH-1:0] lane_v,
    output logic [WIDTH-1:0] lane_w,
    output logic [WIDTH-1:0] lane_x,
    output logic             frame_done,
    output logic             frame_err,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] dropped
);

    tdm_state_t       state;
    tdm_state_t       state_nxt;
    lane_idx_t        idx;
    logic [WIDTH-1:0] stage [LANES];

    logic load_start;
    logic load_word;
    logic commit;
    logic abort;
    logic drop;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid && frame_start) state_nxt = RECV;
            RECV: if (din_valid && !frame_start && idx == LANE_X) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A frame_start word always (re)opens a frame, whatever the state.
    always_comb begin
        load_start = din_valid && frame_start;
        load_word  = (state == RECV) && din_valid && !frame_start;
        commit     = load_word && (idx == LANE_X);
        abort      = (state == RECV) && din_valid && frame_start;
        drop       = (state == IDLE) && din_valid && !frame_start;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx        <= LANE_U;
            for (int i = 0; i < LANES; i++) stage[i] <= '0;
            lane_u     <= '0;
            lane_v     <= '0;
            lane_w     <= '0;
            lane_x     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_data    <= '0;
            dropped    <= '0;
        end else begin
            frame_done <= commit;
            frame_err  <= abort;

            if (load_start) begin
                stage[LANE_U] <= din;
                for (int i = 1; i < LANES; i++) stage[i] <= '0;
                idx <= LANE_V;
            end else if (load_word) begin
                stage[idx] <= din;
                idx        <= idx + 2'd1;
            end

            // Lane x takes din directly so all four lanes move on the same edge.
            if (commit) begin
                lane_u <= stage[LANE_U];
                lane_v <= stage[LANE_V];
                lane_w <= stage[LANE_W];
                lane_x <= din;
            end

            if (drop && dropped != '1) begin
                dropped <= dropped + 1'b1;
            end

            case (rd_sel)
                LANE_U:  rd_data <= lane_u;
                LANE_V:  rd_data <= lane_v;
                LANE_W:  rd_data <= lane_w;
                default: rd_data <= lane_x;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb/tb_tdm_demux_4.sv - scoreboard bench for tdm_demux_4
module tb_tdm_demux_4;

    logic       clk;
    logic       reset;
    logic [1:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [1:0] lane_u, lane_v, lane_w, lane_x;
    logic       frame_done, frame_err;
    logic [1:0] rd_sel;
    logic [1:0] rd_data;
    logic [7:0] dropped;

    tdm_demux_4 #(.WIDTH(2), .CNT_W(8)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .lane_u     (lane_u),
        .lane_v     (lane_v),
        .lane_w     (lane_w),
        .lane_x     (lane_x),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .dropped    (dropped)
    );

    typedef struct {
        bit       is_err;
        int       cyc;
        bit [7:0] lanes;
    } evt_t;

    evt_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit [7:0] lanes_now();
        return {lane_u, lane_v, lane_w, lane_x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input bit v, input bit s, input bit [1:0] d);
        @(negedge clk);
        din_valid   = v;
        frame_start = s;
        din         = d;
    endtask

    // Called right after send(): the word is sampled on the coming edge, pulse seen one cycle later.
    task automatic expect_evt(input bit is_err, input bit [7:0] lanes);
        evt_t e;
        e.is_err = is_err;
        e.cyc    = cyc + 1;
        e.lanes  = lanes;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 2'd0);
    endtask

    task automatic frame(input bit [7:0] w, input int gap);
        send(1'b1, 1'b1, w[7:6]);
        idle(gap);
        send(1'b1, 1'b0, w[5:4]);
        idle(gap);
        send(1'b1, 1'b0, w[3:2]);
        idle(gap);
        send(1'b1, 1'b0, w[1:0]);
        expect_evt(1'b0, w);
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises a pulse.
    always begin
        evt_t e;
        @(posedge clk);
        #2;
        if (!reset && (frame_done || frame_err)) begin
            chk("done_err_exclusive", 32'(frame_done & frame_err), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({frame_done, frame_err}), 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind",  32'(frame_err), 32'(e.is_err));
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_lanes", 32'(lanes_now()), 32'(e.lanes));
            end
        end
    end

    initial begin
        bit [7:0] lv;
        reset = 1'b0; din = '0; din_valid = 1'b0; frame_start = 1'b0; rd_sel = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_lanes",   32'(lanes_now()), 0);
        chk("rst_done",    32'(frame_done), 0);
        chk("rst_err",     32'(frame_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_dropped", 32'(dropped), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Clean contiguous frame 1,2,3,0
        frame(8'b01_10_11_00, 0);
        idle(3);
        chk("clean_lanes", 32'(lanes_now()), 32'(8'b01_10_11_00));

        // Readback sweep with one-cycle lag
        lv = 8'b01_10_11_00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_sel = 2'(i);
            @(negedge clk);
            chk("rd_sweep", 32'(rd_data), 32'(lv[(3-i)*2 +: 2]));
        end

        // Gapped frame, same words
        frame(8'b01_10_11_00, 3);
        idle(3);
        chk("gapped_lanes", 32'(lanes_now()), 32'(8'b01_10_11_00));

        // Abort then restart; rd_sel=v checks commit-cycle read returns old value
        rd_sel = 2'd1;
        send(1'b1, 1'b1, 2'd3);
        send(1'b1, 1'b0, 2'd2);
        send(1'b1, 1'b1, 2'd1);
        expect_evt(1'b1, 8'b01_10_11_00);
        send(1'b1, 1'b0, 2'd1);
        send(1'b1, 1'b0, 2'd1);
        chk("abort_lanes_hold", 32'(lanes_now()), 32'(8'b01_10_11_00));
        send(1'b1, 1'b0, 2'd1);
        expect_evt(1'b0, 8'b01_01_01_01);
        @(negedge clk);
        din_valid = 1'b0; frame_start = 1'b0;
        chk("rd_commit_old", 32'(rd_data), 2);
        @(negedge clk);
        chk("rd_commit_new", 32'(rd_data), 1);
        chk("abort_dropped", 32'(dropped), 0);
        idle(2);

        // Drops from IDLE saturate
        for (int i = 0; i < 254; i++) send(1'b1, 1'b0, 2'(i));
        idle(1);
        chk("drop_254", 32'(dropped), 254);
        for (int i = 0; i < 46; i++) send(1'b1, 1'b0, 2'(i));
        idle(2);
        chk("drop_sat", 32'(dropped), 255);
        chk("drop_lanes_hold", 32'(lanes_now()), 32'(8'b01_01_01_01));

        // Back-to-back frames
        frame(8'b10_01_00_11, 0);
        frame(8'b11_11_10_01, 0);
        idle(3);
        chk("b2b_lanes", 32'(lanes_now()), 32'(8'b11_11_10_01));
        chk("b2b_dropped", 32'(dropped), 255);

        // Reset mid-frame
        send(1'b1, 1'b1, 2'd2);
        send(1'b1, 1'b0, 2'd1);
        @(negedge clk);
        din_valid = 1'b0; frame_start = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("midrst_lanes",   32'(lanes_now()), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        chk("midrst_dropped", 32'(dropped), 0);
        chk("midrst_done",    32'({frame_done, frame_err}), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        send(1'b1, 1'b0, 2'd3);
        idle(1);
        chk("post_rst_drop", 32'(dropped), 1);
        frame(8'b01_10_11_00, 0);
        idle(3);
        chk("post_rst_lanes", 32'(lanes_now()), 32'(8'b01_10_11_00));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("missing_pulses", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
